// File: rtl/idelay_tap_seq_if.sv
// Command / delay-line / response bundle for idelay_tap_seq.
// Handshake: a command transfers on the rising edge where CMD_VALID_I and CMD_READY_O are both 1.
interface idelay_tap_seq_if #(
  parameter int C_CH_NUM    = 4,
  parameter int C_TAP_WIDTH = 9
);
  localparam int CW = (C_CH_NUM > 1) ? $clog2(C_CH_NUM) : 1;

  logic                              CMD_VALID_I;
  logic                              CMD_READY_O;
  logic [CW-1:0]                     CMD_CH_I;
  logic [1:0]                        CMD_OP_I;
  logic [C_TAP_WIDTH-1:0]            CMD_VAL_I;
  logic [C_CH_NUM-1:0]               DLY_CE_O;
  logic [C_CH_NUM-1:0]               DLY_INC_O;
  logic [C_CH_NUM-1:0]               DLY_LD_O;
  logic [C_CH_NUM*C_TAP_WIDTH-1:0]   DLY_CNTVALUE_O;
  logic [C_CH_NUM*C_TAP_WIDTH-1:0]   DLY_CNTVALUE_I;
  logic                              RSP_VALID_O;
  logic [C_TAP_WIDTH-1:0]            RSP_VAL_O;
  logic                              RSP_ERR_O;

  modport master (
    output CMD_VALID_I, CMD_CH_I, CMD_OP_I, CMD_VAL_I, DLY_CNTVALUE_I,
    input  CMD_READY_O, DLY_CE_O, DLY_INC_O, DLY_LD_O, DLY_CNTVALUE_O,
           RSP_VALID_O, RSP_VAL_O, RSP_ERR_O
  );

  modport slave (
    input  CMD_VALID_I, CMD_CH_I, CMD_OP_I, CMD_VAL_I, DLY_CNTVALUE_I,
    output CMD_READY_O, DLY_CE_O, DLY_INC_O, DLY_LD_O, DLY_CNTVALUE_O,
           RSP_VALID_O, RSP_VAL_O, RSP_ERR_O
  );
endinterface

// File: rtl/idelay_tap_seq.sv
// Sequences LOAD/INC/DEC/READ commands onto a bank of IDELAY-style delay lines,
// keeping a shadow tap per channel and checking the readback after a settle window.
module idelay_tap_seq #(
  parameter int C_CH_NUM     = 4,
  parameter int C_TAP_WIDTH  = 9,
  parameter int C_TAP_MAX    = 511,
  parameter int C_DLY_VALUE  = 0,
  parameter int C_SETTLE_CYC = 4
) (
  input  logic                 CLK_I,
  input  logic                 RSTN_I,
  idelay_tap_seq_if.slave      bus,
  output logic [1:0]           dbg_state
);
  localparam int W  = C_TAP_WIDTH;
  localparam int CW = (C_CH_NUM > 1) ? $clog2(C_CH_NUM) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  localparam logic [W:0]   TAP_MAX_X = (W+1)'(C_TAP_MAX);
  localparam logic [W-1:0] TAP_RST   = W'(C_DLY_VALUE);
  localparam logic [W-1:0] TAP_ONE   = W'(1);
  localparam logic [3:0]   SETTLE_N  = 4'(C_SETTLE_CYC);

  logic [1:0]          state;
  logic [3:0]          settle_cnt;
  logic [W-1:0]        shadow [C_CH_NUM];
  logic [CW-1:0]       ch_q;
  logic                ready_q;
  logic [C_CH_NUM-1:0] ce_q, inc_q, ld_q;
  logic                rsp_valid_q, rsp_err_q;
  logic [W-1:0]        rsp_val_q;

  logic                accept, ch_ok, cmd_err;
  logic [W-1:0]        cur_tap, new_tap, readback;
  logic [C_CH_NUM-1:0] ch_hot;

  // ready_q is only ever 1 in IDLE, so accept needs no separate state test.
  assign accept = bus.CMD_VALID_I & ready_q;
  assign ch_ok  = int'(bus.CMD_CH_I) < C_CH_NUM;

  always_comb begin
    cur_tap = '0;
    ch_hot  = '0;
    if (ch_ok) begin
      cur_tap               = shadow[bus.CMD_CH_I];
      ch_hot[bus.CMD_CH_I]  = 1'b1;
    end
  end

  // Out-of-range results are rejected up front, so tap arithmetic never wraps.
  always_comb begin
    cmd_err = !ch_ok;
    new_tap = cur_tap;
    case (bus.CMD_OP_I)
      OP_LOAD: begin
        if ({1'b0, bus.CMD_VAL_I} > TAP_MAX_X) cmd_err = 1'b1;
        new_tap = bus.CMD_VAL_I;
      end
      OP_INC: begin
        if ({1'b0, cur_tap} == TAP_MAX_X) cmd_err = 1'b1;
        new_tap = cur_tap + TAP_ONE;
      end
      OP_DEC: begin
        if (cur_tap == '0) cmd_err = 1'b1;
        new_tap = cur_tap - TAP_ONE;
      end
      default: new_tap = cur_tap;
    endcase
  end

  assign readback = bus.DLY_CNTVALUE_I[int'(ch_q)*W +: W];

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      ch_q        <= '0;
      ready_q     <= 1'b0;
      ce_q        <= '0;
      inc_q       <= '0;
      ld_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_val_q   <= '0;
      for (int n = 0; n < C_CH_NUM; n++) shadow[n] <= TAP_RST;
    end else begin
      ce_q        <= '0;
      inc_q       <= '0;
      ld_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_val_q   <= '0;
      case (state)
        S_IDLE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (accept) begin
            ready_q <= 1'b0;
            ch_q    <= bus.CMD_CH_I;
            if (cmd_err) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_val_q   <= cur_tap;
            end else begin
              // Shadow moves with the strobe so CNTVALUEIN already holds the new tap during ISSUE.
              state                 <= S_ISSUE;
              shadow[bus.CMD_CH_I]  <= new_tap;
              case (bus.CMD_OP_I)
                OP_LOAD: ld_q <= ch_hot;
                OP_INC: begin
                  ce_q  <= ch_hot;
                  inc_q <= ch_hot;
                end
                OP_DEC:  ce_q <= ch_hot;
                default: ;
              endcase
            end
          end
        end
        S_ISSUE: begin
          state      <= S_SETTLE;
          settle_cnt <= SETTLE_N;
        end
        S_SETTLE: begin
          if (settle_cnt <= 4'd1) begin
            state       <= S_RESP;
            settle_cnt  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_val_q   <= readback;
            rsp_err_q   <= (readback != shadow[ch_q]);
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.DLY_CNTVALUE_O = '0;
    for (int n = 0; n < C_CH_NUM; n++) bus.DLY_CNTVALUE_O[n*W +: W] = shadow[n];
  end

  assign bus.CMD_READY_O = ready_q;
  assign bus.DLY_CE_O    = ce_q;
  assign bus.DLY_INC_O   = inc_q;
  assign bus.DLY_LD_O    = ld_q;
  assign bus.RSP_VALID_O = rsp_valid_q;
  assign bus.RSP_VAL_O   = rsp_val_q;
  assign bus.RSP_ERR_O   = rsp_err_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_idelay_tap_seq.sv
// Randomized bench for idelay_tap_seq against a per-channel tap model and an
// echoing delay-line model with optional forced readback.
module tb_idelay_tap_seq;
  localparam int CH     = 4;
  localparam int TW     = 9;
  localparam int TMAX   = 511;
  localparam int SETTLE = 4;
  localparam int EW     = TW + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;
  idelay_tap_seq_if #(.C_CH_NUM(CH), .C_TAP_WIDTH(TW)) bus ();

  idelay_tap_seq #(
    .C_CH_NUM(CH), .C_TAP_WIDTH(TW), .C_TAP_MAX(TMAX),
    .C_DLY_VALUE(0), .C_SETTLE_CYC(SETTLE)
  ) dut (
    .CLK_I(clk), .RSTN_I(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  // delay-line model: echoes CNTVALUEIN one cycle later unless a channel is forced
  int              force_ch  = -1;
  logic [TW-1:0]   force_val = '0;
  logic [CH*TW-1:0] echo;
  always @(posedge clk) begin
    for (int n = 0; n < CH; n++)
      echo[n*TW +: TW] <= (n == force_ch) ? force_val : bus.DLY_CNTVALUE_O[n*TW +: TW];
  end
  assign bus.DLY_CNTVALUE_I = echo;

  // scoreboard
  int taps [CH];
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model of one accepted command
  task automatic model_cmd(input int ch, input int op, input int val,
                           output int lat, output int ce, output int inc, output int ld);
    int  cur;
    bit  err;
    int  rval;
    cur = (ch < CH) ? taps[ch] : 0;
    err = (ch >= CH) || (op == 0 && val > TMAX) || (op == 1 && cur == TMAX) || (op == 2 && cur == 0);
    ce = 0; inc = 0; ld = 0;
    if (err) begin
      lat  = 1;
      rval = cur;
    end else begin
      lat = 2 + SETTLE;
      case (op)
        0: begin taps[ch] = val;     ld = 1 << ch; end
        1: begin taps[ch] = cur + 1; ce = 1 << ch; inc = 1 << ch; end
        2: begin taps[ch] = cur - 1; ce = 1 << ch; end
        default: ;
      endcase
      rval = (ch == force_ch) ? int'(force_val) : taps[ch];
      err  = (rval != taps[ch]);
    end
    exp_q.push_back({err, rval[TW-1:0]});
  endtask

  task automatic check_rsp(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_val"}, bus.RSP_VAL_O, e[TW-1:0]);
      check({tag, "_err"}, bus.RSP_ERR_O, e[TW]);
    end
  endtask

  task automatic check_shadows(input string tag);
    for (int n = 0; n < CH; n++)
      check($sformatf("%s_sh%0d", tag, n), bus.DLY_CNTVALUE_O[n*TW +: TW], taps[n]);
  endtask

  task automatic drive_rand_fields();
    bus.CMD_CH_I  = 2'($urandom_range(0, CH-1));
    bus.CMD_OP_I  = 2'($urandom_range(0, 3));
    bus.CMD_VAL_I = TW'($urandom_range(0, TMAX));
  endtask

  // driver: one command with full latency / strobe / response checks; entered and left at a negedge
  task automatic do_cmd(input string tag, input int ch, input int op, input int val);
    int lat, ce, inc, ld, extra, k;
    bit got;
    k = 0;
    while (!bus.CMD_READY_O && k < 20) begin @(negedge clk); k++; end
    check({tag, "_ready"}, bus.CMD_READY_O, 1);
    bus.CMD_CH_I    = 2'(ch);
    bus.CMD_OP_I    = 2'(op);
    bus.CMD_VAL_I   = TW'(val);
    bus.CMD_VALID_I = 1'b1;
    model_cmd(ch, op, val, lat, ce, inc, ld);
    @(posedge clk);
    #1;
    bus.CMD_VALID_I = 1'b0;
    drive_rand_fields();
    got   = 1'b0;
    extra = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_ce"},  bus.DLY_CE_O,  ce);
        check({tag, "_inc"}, bus.DLY_INC_O, inc);
        check({tag, "_ld"},  bus.DLY_LD_O,  ld);
      end else begin
        extra = extra | int'(bus.DLY_CE_O) | int'(bus.DLY_INC_O) | int'(bus.DLY_LD_O);
      end
      if (bus.RSP_VALID_O) begin
        check({tag, "_lat"}, c, lat);
        check_rsp(tag);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check({tag, "_rsp_timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end
    check({tag, "_extra_strobe"}, extra, 0);
    check_shadows(tag);
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, bus.RSP_VALID_O, 0);
    check({tag, "_ready_after_rsp"}, bus.CMD_READY_O, 1);
  endtask

  // reset asserted c cycles after accepting INC ch1 (1 = during ISSUE, 3 = during SETTLE)
  task automatic reset_mid(input string tag, input int at_cycle);
    int k;
    k = 0;
    while (!bus.CMD_READY_O && k < 20) begin @(negedge clk); k++; end
    bus.CMD_CH_I    = 2'd1;
    bus.CMD_OP_I    = 2'd1;
    bus.CMD_VAL_I   = '0;
    bus.CMD_VALID_I = 1'b1;
    @(posedge clk);
    #1;
    bus.CMD_VALID_I = 1'b0;
    for (int c = 1; c <= at_cycle; c++) begin
      @(negedge clk);
      check({tag, "_no_rsp_pre"}, bus.RSP_VALID_O, 0);
    end
    if (at_cycle == 1) check({tag, "_ce_before_rst"}, bus.DLY_CE_O, 4'b0010);
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < CH; n++) taps[n] = 0;
    force_ch = -1;
    check({tag, "_ce_drop"}, bus.DLY_CE_O, 0);
    check({tag, "_inc_drop"}, bus.DLY_INC_O, 0);
    check({tag, "_ready_in_rst"}, bus.CMD_READY_O, 0);
    check({tag, "_state_in_rst"}, dbg_state, 0);
    check_shadows(tag);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check({tag, "_rsp_in_rst"}, bus.RSP_VALID_O, 0);
    end
    rst_n = 1'b1;
    #1;
    check({tag, "_ready_pre_edge"}, bus.CMD_READY_O, 0);
    @(negedge clk);
    check({tag, "_ready_post_edge"}, bus.CMD_READY_O, 1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check({tag, "_no_rsp_post"}, bus.RSP_VALID_O, 0);
    end
  endtask

  // valid held high with fields changing every cycle
  task automatic stream_test(input int cycles);
    int lat, ce, inc, ld;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.RSP_VALID_O) check_rsp("stream");
      drive_rand_fields();
      if ($urandom_range(0, 3) == 0) bus.CMD_VAL_I = TW'(TMAX);
      bus.CMD_VALID_I = 1'b1;
      if (bus.CMD_READY_O)
        model_cmd(int'(bus.CMD_CH_I), int'(bus.CMD_OP_I), int'(bus.CMD_VAL_I), lat, ce, inc, ld);
    end
    @(posedge clk);
    #1;
    bus.CMD_VALID_I = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bus.RSP_VALID_O) check_rsp("stream_drain");
    end
    check("stream_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check_shadows("stream");
  endtask

  initial begin
    int ch, op, val;
    bus.CMD_VALID_I = 1'b0;
    bus.CMD_CH_I    = '0;
    bus.CMD_OP_I    = '0;
    bus.CMD_VAL_I   = '0;
    for (int n = 0; n < CH; n++) taps[n] = 0;

    repeat (3) @(negedge clk);
    check("rst_ready", bus.CMD_READY_O, 0);
    check("rst_rsp_valid", bus.RSP_VALID_O, 0);
    check("rst_rsp_val", bus.RSP_VAL_O, 0);
    check("rst_rsp_err", bus.RSP_ERR_O, 0);
    check("rst_strobes", {bus.DLY_CE_O, bus.DLY_INC_O, bus.DLY_LD_O}, 0);
    check_shadows("rst");
    rst_n = 1'b1;
    #1;
    check("rst_ready_pre_edge", bus.CMD_READY_O, 0);
    @(negedge clk);
    check("rst_ready_post_edge", bus.CMD_READY_O, 1);

    do_cmd("load_ch2_100", 2, 0, 100);
    do_cmd("inc_ch0", 0, 1, 0);
    do_cmd("dec_ch0_a", 0, 2, 0);
    do_cmd("dec_ch0_err", 0, 2, 0);
    do_cmd("load_ch1_511", 1, 0, 511);
    do_cmd("inc_ch1_err", 1, 1, 0);
    do_cmd("load_ch3_9", 3, 0, 9);
    force_ch  = 3;
    force_val = 9'd7;
    do_cmd("read_ch3_forced", 3, 3, 0);
    force_ch = -1;
    do_cmd("read_ch3_clean", 3, 3, 0);

    do_cmd("pre_rst_load", 1, 0, 50);
    reset_mid("rst_settle", 3);
    do_cmd("pre_rst_load2", 1, 0, 60);
    reset_mid("rst_issue", 1);

    for (int i = 0; i < 150; i++) begin
      ch = $urandom_range(0, CH-1);
      op = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       val = TMAX;
        1:       val = 0;
        default: val = $urandom_range(0, TMAX);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        force_ch  = $urandom_range(0, CH-1);
        force_val = TW'($urandom_range(0, TMAX));
      end else begin
        force_ch = -1;
      end
      do_cmd($sformatf("rnd%0d", i), ch, op, val);
    end
    force_ch = -1;
    @(negedge clk);

    stream_test(120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
